// File: rtl/regfile_pkg.sv
// ============================================================================
//  regfile_pkg : shared sizing constants for the 32-entry register file
//  Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/rf_word.sv
// ============================================================================
//  rf_word : one DATA_W-bit storage word, load-enabled, async active-low clear
//  Rev 1.0
// ============================================================================
`default_nettype none

module rf_word #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    import regfile_pkg::*;

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        data_d = en ? d : data_q;
    end

    // Reset has priority over a coincident clock edge, so a pending write is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : rf_word

`default_nettype wire

// File: rtl/regfile32.sv
// ============================================================================
//  regfile32 : 2-read / 1-write register file, word 0 hard-wired to zero
//  Rev 1.0
// ============================================================================
`default_nettype none

module regfile32 #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    import regfile_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:1]  w_en;
    logic [DATA_W-1:0] word_q [DEPTH];

    // Word 0 has no storage; it is the constant-zero input of both read muxes.
    assign word_q[ZERO_REG] = '0;

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_word
            assign w_en[i] = we & (waddr == ADDR_W'(i));

            rf_word #(
                .DATA_W (DATA_W)
            ) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_en[i]),
                .d     (wdata),
                .q     (word_q[i])
            );
        end
    endgenerate

    // Reads are straight from the flops: no bypass of a same-cycle write.
    assign rdata1 = word_q[raddr1];
    assign rdata2 = word_q[raddr2];

endmodule : regfile32

`default_nettype wire

// File: tb/tb_regfile32.sv
// ============================================================================
//  tb_regfile32 : randomized self-checking bench against an array model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile32;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NW = 32;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;

    logic [DW-1:0] mdl [NW];
    int            n_vec;
    int            n_err;

    regfile32 #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no end of test, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NW; i++) mdl[i] = '0;
    endtask

    task automatic mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a != 0) mdl[a] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input string tag);
        raddr1 = a1;
        raddr2 = a2;
        #1;
        chk($sformatf("%s rd1[%0d]", tag, a1), rdata1, mdl[a1]);
        chk($sformatf("%s rd2[%0d]", tag, a2), rdata2, mdl[a2]);
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < NW; i++) rd(AW'(i), AW'(NW - 1 - i), tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        mdl_write(a, d);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        mdl_clear();

        // Reset state, with a write attempt held across edges while in reset
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        we = 1'b0;
        rd_all("reset");

        // First rising edge after deassertion accepts a write
        @(negedge clk);
        rst_n = 1'b1;
        wr(5'd9, 32'h0BAD_F00D);
        rd(5'd9, 5'd3, "first-write");

        // Basic write and neighbour isolation
        wr(5'd5, 32'hDEAD_BEEF);
        rd(5'd5, 5'd5, "addr5");
        rd(5'd4, 5'd6, "neighbours");

        // Writes to address 0 are discarded
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 5'd0, "zero-reg");

        // Same-cycle read and write: old value before the edge, new after
        @(negedge clk);
        raddr1 = 5'd7;
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'h1234_5678;
        #1;
        chk("no-bypass before edge", rdata1, 32'h0000_0000);
        @(posedge clk);
        #1;
        we = 1'b0;
        mdl_write(5'd7, 32'h1234_5678);
        chk("no-bypass after edge", rdata1, 32'h1234_5678);

        // Full fill, then asynchronous reset pulse away from any clock edge
        for (int i = 1; i < NW; i++) wr(AW'(i), DW'(i) * 32'h0101_0101);
        rd_all("fill");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mdl_clear();
        raddr1 = 5'd31;
        raddr2 = 5'd17;
        #0.5;
        chk("async clear rd1[31]", rdata1, 32'h0000_0000);
        chk("async clear rd2[17]", rdata2, 32'h0000_0000);
        rd_all("async-reset");
        @(negedge clk);
        rst_n = 1'b1;
        wr(5'd31, 32'hA5A5_A5A5);
        rd(5'd31, 5'd30, "after-reset");

        // Back-to-back writes interrupted by reset leave nothing behind
        wr(5'd10, 32'h1111_1111);
        wr(5'd11, 32'h2222_2222);
        @(negedge clk);
        rst_n = 1'b0;
        mdl_clear();
        @(negedge clk);
        rst_n = 1'b1;
        rd_all("reset-between-writes");

        // Randomized mixed traffic, reads checked before each edge
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we     = 1'($urandom_range(0, 1));
            waddr  = AW'($urandom);
            wdata  = DW'($urandom);
            raddr1 = AW'($urandom);
            raddr2 = ($urandom_range(0, 7) == 0) ? raddr1 : AW'($urandom);
            #1;
            chk($sformatf("rand rd1[%0d]", raddr1), rdata1, mdl[raddr1]);
            chk($sformatf("rand rd2[%0d]", raddr2), rdata2, mdl[raddr2]);
            @(posedge clk);
            if (we) mdl_write(waddr, wdata);
        end
        #1;
        we = 1'b0;

        // Known fill, then 100 cycles of we=0 with random address/data
        for (int i = 0; i < NW; i++) wr(AW'(i), 32'h5A00_0000 ^ DW'($urandom));
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            we    = 1'b0;
            waddr = AW'($urandom);
            wdata = DW'($urandom);
        end
        rd_all("hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile32

`default_nettype wire

// File: doc/regfile32.md
REGFILE32 -- requirements
Module: regfile32

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W = 32 words.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all storage.
REQ-005 rst_n  input  1  asynchronous active-low reset; clears every word.
REQ-006 we  input  1  write enable, sampled on the rising edge of clk.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 raddr1  input  ADDR_W  read port 1 address.
REQ-010 rdata1  output  DATA_W  read port 1 data.
REQ-011 raddr2  input  ADDR_W  read port 2 address.
REQ-012 rdata2  output  DATA_W  read port 2 data.

Function
REQ-013 On a rising clk edge with rst_n=1, we=1 and waddr!=0, word[waddr] SHALL load wdata.
REQ-014 When we=0, every word SHALL hold its value.
REQ-015 Word 0 SHALL read as 0 at all times; writes to address 0 SHALL be discarded.
REQ-016 rdata1/rdata2 SHALL be combinational: rdata1 = word[raddr1], rdata2 = word[raddr2], with zero-cycle latency from the address.
REQ-017 Same-cycle read and write of one address SHALL return the old value before the edge and the new value after it (no write-to-read bypass).
REQ-018 Both read ports SHALL be independent; equal raddr1/raddr2 SHALL return identical data.
REQ-019 A write SHALL affect only the addressed word; all other 30 writable words SHALL remain unchanged.
REQ-020 X/Z on waddr while we=1 SHALL NOT be relied upon; the bench keeps waddr known whenever we=1.

Reset
REQ-021 When rst_n=0, all words SHALL clear to 0 immediately, without waiting for clk, and rdata1/rdata2 SHALL read 0.
REQ-022 While rst_n=0, we SHALL be ignored, including a clock edge that coincides with reset assertion.
REQ-023 On rst_n deassertion, the first rising edge with rst_n=1 SHALL accept a write.
REQ-024 Reset asserted between back-to-back writes SHALL leave every word at 0; writes before the reset SHALL NOT persist.

Structure
REQ-025 DATA_W, ADDR_W and the zero-register index SHALL live in the shared package regfile_pkg.
REQ-026 One sub-module, rf_word, SHALL be used: a DATA_W-bit flop word with clk, rst_n (async active-low clear), en and d/q ports. It SHALL be instantiated 31 times (words 1..31) in a generate loop.
REQ-027 A decoder SHALL produce the per-word enables: en[i] = we & (waddr==i), for i = 1..31.
REQ-028 Each read port SHALL be a 32:1 multiplexer, with input 0 tied to 0.

Verification
REQ-029 Reset, then read all 32 addresses on both ports -> all return 32'h0000_0000.
REQ-030 Write 32'hDEAD_BEEF to addr 5, then read raddr1=5 and raddr2=5 -> both return 32'hDEAD_BEEF; addr 4 and addr 6 return 0.
REQ-031 Write 32'hFFFF_FFFF to addr 0 -> rdata1 at raddr1=0 returns 0.
REQ-032 Hold raddr1=7 and write 32'h1234_5678 to addr 7 -> rdata1 returns the old 0 before the edge and 32'h1234_5678 after it.
REQ-033 Fill addr i with i*32'h0101_0101 for i = 1..31, then pulse rst_n low mid-cycle with no clk edge -> all reads return 0 at once; a later write of 32'hA5A5_A5A5 to addr 31 reads back correctly.
REQ-034 Set we=0 with random waddr/wdata for 100 cycles after a known fill -> every word is unchanged.
